dpram_port_arbiter: RTL and testbench
=====================================

# dpram_port_arbiter

Round-robin arbiter that shares the two ports of the 2048×60 dual-port RAM among NUM_REQ independent requesters. Each cycle it grants up to two requests, one per RAM port, and drives the registered RAM inputs. It returns read data to the owning requester with a fixed latency. It sits between compute tiles and the `dpram` instance, which it instantiates.

## Interface

- NUM_REQ, 4, number of requesters (2..8)
- AWIDTH, 11, RAM address width
- NUM_WORDS, 2048, RAM depth
- DWIDTH, 60, RAM data width

Ports:

- clk  in  1  single clock, all logic on posedge
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  request present, one bit per requester
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*AWIDTH  flattened addresses; requester i uses slice [i*AWIDTH +: AWIDTH]
- req_wdata  in  NUM_REQ*DWIDTH  flattened write data
- req_ready  out  NUM_REQ  grant; the request is accepted when valid & ready
- rsp_valid  out  NUM_REQ  read data valid for requester i, one-cycle pulse
- rsp_data  out  NUM_REQ*DWIDTH  flattened read data; valid only when rsp_valid[i]=1

## Operation

- Rotating priority pointer `ptr` (0..NUM_REQ-1).
- Search order is ptr, ptr+1, … modulo NUM_REQ.
- First valid requester in search order → grant on port A.
- Second valid requester → grant on port B, unless it conflicts with the port A grant.
  - Conflict = same address and at least one of the two is a write.
  - On conflict, port B idles and the second requester waits.
  - A third candidate is never promoted to port B in that cycle.
- Pointer update, only when at least one grant is made:
  - Advances to (last granted index + 1) mod NUM_REQ.
  - With no grants it holds.
- req_ready is combinational from req_valid, req_addr, req_we and ptr. It is never asserted without the matching req_valid.
- Issue stage, registered on the accept edge:
  - address_x, wren_x and data_x of the granted request are loaded into the RAM port drivers.
  - Idle port: wren_x=0 and address held. The read result is discarded.
- Tag pipeline per port, two stages: {valid, requester index, is_read}.
  - On stage-2, if valid & is_read: rsp_valid[index]=1 and rsp_data[index] = out_x.
- Writes produce no response.
- Both ports may return to the same requester only if it was granted on both ports. This is impossible because a requester holds at most one grant per cycle, so at most one rsp_valid per requester per cycle.
- The RAM keeps its last out_x on write cycles. The arbiter never consumes out_x for a write slot.
- Responses have no backpressure. A requester must be able to sink one response per cycle.

## Timing

- Accept at edge N.
- RAM inputs are valid after edge N.
- RAM out_x is valid after edge N+1.
- rsp_valid and rsp_data are registered after edge N+2: read latency is 2 cycles, accept to response.
- Throughput: 2 accesses/cycle when there is no conflict.
- Fairness: a continuously valid requester is granted within NUM_REQ-1 cycles.
- Reset (async assert):
  - ptr=0, all tag valids=0, rsp_valid=0, rsp_data=0, RAM wren=0, RAM address=0.
  - In-flight reads are dropped with no response.
  - Writes already issued to the RAM may or may not complete.
- Deassertion is synchronized externally. The first grant can occur on the first edge after release.

## Structure

- Package `dpram_arb_pkg`:
  - AWIDTH, DWIDTH, NUM_WORDS defaults.
  - Tag struct {valid, idx[$clog2(NUM_REQ)-1:0], is_read}.
  - Conflict-check function.
- Sub-module `rr_pick2`: combinational picker that returns the first and second valid index from the pointer, plus their found flags.
- The top level holds the pointer, issue registers, tag pipeline, response demux and the `dpram` instance.

## Test plan

- Single read: requester 2 reads addr 0x005 (preloaded 60'h0ABC) → req_ready[2]=1 the same cycle; rsp_valid[2]=1 with data 60'h0ABC exactly 2 cycles later; all other rsp_valid stay 0.
- Dual issue: req 0 writes 0x010=60'h1, req 1 reads 0x020, ptr=0 → both granted in one cycle (A=0, B=1); ptr becomes 2; the read response arrives 2 cycles later.
- Conflict: req 0 and req 1 both write addr 0x7FF, ptr=0 → only req 0 granted; req 1 granted next cycle; a final read of 0x7FF returns req 1's data.
- Fairness: all 4 requesters continuously reading distinct addresses → grant pairs (0,1),(2,3),(0,1)…; each requester gets exactly one response every 2 cycles.
- Reset mid-flight: resetn asserted 1 cycle after two reads are accepted → no rsp_valid ever appears for them; ptr=0; after release the first grant goes to requester 0.
- Wrap: ptr=3, requesters 3 and 0 valid → A=3, B=0; ptr becomes 1.

Source files
------------

// File: rtl/dpram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dpram_arb_pkg
// Description : Shared defaults, response tag type and port-conflict check
//               for the dual-port RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dpram_arb_pkg;

    localparam int AWIDTH    = 11;
    localparam int DWIDTH    = 60;
    localparam int NUM_WORDS = 2048;

    // Tags are sized for the largest supported requester count so the type
    // does not depend on the arbiter's NUM_REQ parameter.
    localparam int C_MAX_REQ   = 8;
    localparam int C_TAG_IDX_W = $clog2(C_MAX_REQ);

    // Travels alongside each RAM access until its read data emerges.
    typedef struct packed {
        logic                   valid;
        logic [C_TAG_IDX_W-1:0] idx;
        logic                   is_read;
    } tag_t;

    // Two same-cycle accesses collide when they touch the same word and at
    // least one of them writes it.
    function automatic logic addr_conflict(
        input logic [31:0] addr_a,
        input logic        we_a,
        input logic [31:0] addr_b,
        input logic        we_b
    );
        return (addr_a == addr_b) && (we_a || we_b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dpram.sv
`default_nettype none
// ============================================================================
// Module      : dpram
// Description : True dual-port synchronous RAM. A port that writes keeps its
//               previous output word; a port that reads registers the word.
// Revision    : 1.0 - initial release
// ============================================================================
module dpram #(
    parameter int AWIDTH    = 11,
    parameter int DWIDTH    = 60,
    parameter int NUM_WORDS = 2048
) (
    input  logic              clk,
    input  logic [AWIDTH-1:0] address_a,
    input  logic [AWIDTH-1:0] address_b,
    input  logic              wren_a,
    input  logic              wren_b,
    input  logic [DWIDTH-1:0] data_a,
    input  logic [DWIDTH-1:0] data_b,
    output logic [DWIDTH-1:0] out_a,
    output logic [DWIDTH-1:0] out_b
);

    logic [DWIDTH-1:0] mem [NUM_WORDS];

    // Both ports share the array; the arbiter never issues colliding writes.
    always_ff @(posedge clk) begin
        if (wren_a) begin
            mem[address_a] <= data_a;
        end else begin
            out_a <= mem[address_a];
        end
        if (wren_b) begin
            mem[address_b] <= data_b;
        end else begin
            out_b <= mem[address_b];
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational round-robin picker. Returns the first and the
//               second valid requester in the order ptr, ptr+1, ... (mod N).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic               first_found,
    output logic [IDX_W-1:0]   first_idx,
    output logic               second_found,
    output logic [IDX_W-1:0]   second_idx
);

    // Walk the requesters starting at ptr and keep the first two hits.
    always_comb begin
        int               pos;
        logic [IDX_W-1:0] sel;
        first_found  = 1'b0;
        first_idx    = '0;
        second_found = 1'b0;
        second_idx   = '0;
        pos          = 0;
        sel          = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            sel = IDX_W'(pos);
            if (valid[sel]) begin
                if (!first_found) begin
                    first_found = 1'b1;
                    first_idx   = sel;
                end else if (!second_found) begin
                    second_found = 1'b1;
                    second_idx   = sel;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dpram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dpram_port_arbiter
// Description : Shares the two ports of a dual-port RAM among NUM_REQ
//               requesters with a rotating priority pointer. Grants up to
//               two requests per cycle and returns read data two cycles
//               after acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module dpram_port_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int AWIDTH    = dpram_arb_pkg::AWIDTH,
    parameter int NUM_WORDS = dpram_arb_pkg::NUM_WORDS,
    parameter int DWIDTH    = dpram_arb_pkg::DWIDTH
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*AWIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DWIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [NUM_REQ*DWIDTH-1:0] rsp_data
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [AWIDTH-1:0] w_addr [NUM_REQ];
    logic [DWIDTH-1:0] w_wdata[NUM_REQ];

    logic              first_found, second_found;
    logic [IDX_W-1:0]  first_idx, second_idx;
    logic              grant_a, grant_b;

    logic [IDX_W-1:0]  ptr_q, ptr_d;

    logic [AWIDTH-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic              wren_a_q, wren_a_d, wren_b_q, wren_b_d;
    logic [DWIDTH-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
    logic [DWIDTH-1:0] out_a, out_b;

    tag_t              tag1_a_q, tag1_a_d, tag1_b_q, tag1_b_d;
    tag_t              tag2_a_q, tag2_a_d, tag2_b_q, tag2_b_d;

    logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ*DWIDTH-1:0] rsp_data_q, rsp_data_d;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr[gi]  = req_addr[gi*AWIDTH +: AWIDTH];
            assign w_wdata[gi] = req_wdata[gi*DWIDTH +: DWIDTH];
        end
    endgenerate

    rr_pick2 #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .valid        (req_valid),
        .ptr          (ptr_q),
        .first_found  (first_found),
        .first_idx    (first_idx),
        .second_found (second_found),
        .second_idx   (second_idx)
    );

    // Grant decision: port B only takes the second candidate, and only when
    // it does not collide with port A; a third candidate never moves up.
    always_comb begin
        grant_a   = first_found;
        grant_b   = second_found &&
                    !addr_conflict(32'(w_addr[first_idx]),  req_we[first_idx],
                                   32'(w_addr[second_idx]), req_we[second_idx]);
        req_ready = '0;
        if (grant_a) begin
            req_ready[first_idx] = 1'b1;
        end
        if (grant_b) begin
            req_ready[second_idx] = 1'b1;
        end
        ptr_d = ptr_q;
        if (grant_b) begin
            ptr_d = (second_idx == IDX_W'(NUM_REQ - 1)) ? '0 : second_idx + 1'b1;
        end else if (grant_a) begin
            ptr_d = (first_idx == IDX_W'(NUM_REQ - 1)) ? '0 : first_idx + 1'b1;
        end
    end

    // Next RAM port drive and first tag stage; idle ports read the held address.
    always_comb begin
        addr_a_d = addr_a_q;
        wren_a_d = 1'b0;
        data_a_d = data_a_q;
        tag1_a_d = '0;
        addr_b_d = addr_b_q;
        wren_b_d = 1'b0;
        data_b_d = data_b_q;
        tag1_b_d = '0;
        if (grant_a) begin
            addr_a_d         = w_addr[first_idx];
            wren_a_d         = req_we[first_idx];
            data_a_d         = w_wdata[first_idx];
            tag1_a_d.valid   = 1'b1;
            tag1_a_d.idx     = C_TAG_IDX_W'(first_idx);
            tag1_a_d.is_read = !req_we[first_idx];
        end
        if (grant_b) begin
            addr_b_d         = w_addr[second_idx];
            wren_b_d         = req_we[second_idx];
            data_b_d         = w_wdata[second_idx];
            tag1_b_d.valid   = 1'b1;
            tag1_b_d.idx     = C_TAG_IDX_W'(second_idx);
            tag1_b_d.is_read = !req_we[second_idx];
        end
        tag2_a_d = tag1_a_q;
        tag2_b_d = tag1_b_q;
    end

    // Response demux: stage-2 read tags steer the RAM outputs to their owner.
    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tag2_a_q.valid && tag2_a_q.is_read && (tag2_a_q.idx == C_TAG_IDX_W'(i))) begin
                rsp_valid_d[i]                 = 1'b1;
                rsp_data_d[i*DWIDTH +: DWIDTH] = out_a;
            end
            if (tag2_b_q.valid && tag2_b_q.is_read && (tag2_b_q.idx == C_TAG_IDX_W'(i))) begin
                rsp_valid_d[i]                 = 1'b1;
                rsp_data_d[i*DWIDTH +: DWIDTH] = out_b;
            end
        end
    end

    // Pointer, RAM issue registers and tag pipeline.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q    <= '0;
            addr_a_q <= '0;
            wren_a_q <= 1'b0;
            data_a_q <= '0;
            addr_b_q <= '0;
            wren_b_q <= 1'b0;
            data_b_q <= '0;
            tag1_a_q <= '0;
            tag1_b_q <= '0;
            tag2_a_q <= '0;
            tag2_b_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            addr_a_q <= addr_a_d;
            wren_a_q <= wren_a_d;
            data_a_q <= data_a_d;
            addr_b_q <= addr_b_d;
            wren_b_q <= wren_b_d;
            data_b_q <= data_b_d;
            tag1_a_q <= tag1_a_d;
            tag1_b_q <= tag1_b_d;
            tag2_a_q <= tag2_a_d;
            tag2_b_q <= tag2_b_d;
        end
    end

    // Registered responses; a reset drops anything still in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

    dpram #(
        .AWIDTH    (AWIDTH),
        .DWIDTH    (DWIDTH),
        .NUM_WORDS (NUM_WORDS)
    ) u_ram (
        .clk       (clk),
        .address_a (addr_a_q),
        .address_b (addr_b_q),
        .wren_a    (wren_a_q),
        .wren_b    (wren_b_q),
        .data_a    (data_a_q),
        .data_b    (data_b_q),
        .out_a     (out_a),
        .out_b     (out_b)
    );

endmodule
`default_nettype wire

// File: tb/tb_dpram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dpram_port_arbiter
// Description : Self-checking bench for dpram_port_arbiter: hand-computed
//               vector table, multi-cycle corner sequences and random traffic
//               against a behavioural model of grants, memory and responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dpram_port_arbiter;

    localparam int NR = 4;
    localparam int AW = 11;
    localparam int DW = 60;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NR-1:0]     req_valid, req_we, req_ready, rsp_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata, rsp_data;

    always #5 clk = ~clk;

    dpram_port_arbiter #(
        .NUM_REQ   (NR),
        .AWIDTH    (AW),
        .NUM_WORDS (2048),
        .DWIDTH    (DW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int mptr   = 0;

    // Behavioural model: word store plus the list of promised responses.
    logic [DW-1:0] mmem   [2048];
    bit            mknown [2048];
    typedef struct {
        int            due;
        int            idx;
        logic [DW-1:0] data;
        bit            known;
    } exp_t;
    exp_t pend[$];

    typedef struct packed {
        logic [NR-1:0]    v;
        logic [NR-1:0]    we;
        logic [NR*AW-1:0] a;
        logic [NR*DW-1:0] d;
        logic [NR-1:0]    exp_rdy;
        logic [NR-1:0]    exp_rsp;
    } vec_t;

    vec_t tbl [24];

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] we,
                                input logic [10:0] a0, input logic [10:0] a1,
                                input logic [10:0] a2, input logic [10:0] a3,
                                input logic [59:0] d0, input logic [59:0] d1,
                                input logic [59:0] d2, input logic [59:0] d3,
                                input logic [3:0] er, input logic [3:0] ers);
        vec_t r;
        r.v = v; r.we = we;
        r.a = {a3, a2, a1, a0};
        r.d = {d3, d2, d1, d0};
        r.exp_rdy = er; r.exp_rsp = ers;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_rsp(input bit chk, input logic [NR-1:0] exp_rsp);
        logic [NR-1:0] ev;
        logic [DW-1:0] ed [NR];
        bit            ek [NR];
        ev = '0;
        for (int i = 0; i < NR; i++) begin
            ed[i] = '0;
            ek[i] = 1'b0;
        end
        for (int q = pend.size() - 1; q >= 0; q--) begin
            if (pend[q].due <= cyc) begin
                ev[pend[q].idx] = 1'b1;
                ed[pend[q].idx] = pend[q].data;
                ek[pend[q].idx] = pend[q].known;
                pend.delete(q);
            end
        end
        check("rsp_valid_model", 64'(rsp_valid), 64'(ev));
        if (chk) check("rsp_valid_expected", 64'(rsp_valid), 64'(exp_rsp));
        for (int i = 0; i < NR; i++) begin
            if (ev[i] && ek[i]) check("rsp_data", 64'(rsp_data[i*DW +: DW]), 64'(ed[i]));
        end
    endtask

    task automatic model_accept(input int idx, input logic [NR-1:0] we,
                                input logic [NR*AW-1:0] a, input logic [NR*DW-1:0] d);
        int   ad;
        exp_t e;
        ad = int'(a[idx*AW +: AW]);
        if (we[idx]) begin
            mmem[ad]   = d[idx*DW +: DW];
            mknown[ad] = 1'b1;
        end else begin
            e.due   = cyc + 3;
            e.idx   = idx;
            e.data  = mmem[ad];
            e.known = mknown[ad];
            pend.push_back(e);
        end
    endtask

    // Entered and left at posedge+1; checks grants mid-cycle, responses after the edge.
    task automatic run_cycle(input logic [NR-1:0] v, input logic [NR-1:0] we,
                             input logic [NR*AW-1:0] a, input logic [NR*DW-1:0] d,
                             input bit chk_rdy, input logic [NR-1:0] exp_rdy,
                             input bit chk_rsp, input logic [NR-1:0] exp_rsp);
        int            first, second, j;
        bit            gb;
        logic [NR-1:0] mrdy;
        req_valid = v; req_we = we; req_addr = a; req_wdata = d;
        #3;
        first = -1; second = -1;
        for (int k = 0; k < NR; k++) begin
            j = (mptr + k) % NR;
            if (v[j]) begin
                if (first < 0) first = j;
                else if (second < 0) second = j;
            end
        end
        mrdy = '0; gb = 1'b0;
        if (first >= 0) mrdy[first] = 1'b1;
        if (second >= 0) begin
            gb = !((a[first*AW +: AW] == a[second*AW +: AW]) && (we[first] || we[second]));
            if (gb) mrdy[second] = 1'b1;
        end
        check("ready_model", 64'(req_ready), 64'(mrdy));
        if (chk_rdy) check("ready_expected", 64'(req_ready), 64'(exp_rdy));
        if (first >= 0) begin
            model_accept(first, we, a, d);
            if (gb) model_accept(second, we, a, d);
            mptr = ((gb ? second : first) + 1) % NR;
        end
        @(posedge clk); #1; cyc++;
        check_rsp(chk_rsp, exp_rsp);
    endtask

    task automatic idle(input bit chk_rsp, input logic [NR-1:0] exp_rsp);
        run_cycle('0, '0, '0, '0, 1'b1, '0, chk_rsp, exp_rsp);
    endtask

    // Asserts reset between edges, holds it over one edge and releases mid-cycle.
    task automatic do_reset();
        req_valid = '0;
        resetn = 1'b0;
        #2;
        pend.delete();
        mptr = 0;
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_data_zero", 64'(rsp_data == '0), 64'd1);
        @(posedge clk); #1; cyc++;
        check("reset_hold_rsp_valid", 64'(rsp_valid), 64'd0);
        #3 resetn = 1'b1;
        @(posedge clk); #1; cyc++;
        check_rsp(1'b1, '0);
    endtask

    initial begin
        logic [NR*AW-1:0] fa;
        logic [NR*AW-1:0] ra;
        logic [NR*DW-1:0] rd;
        logic [63:0]      rnd;
        resetn = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 2048; i++) begin
            mmem[i] = '0;
            mknown[i] = 1'b0;
        end
        @(posedge clk); #1;
        do_reset();
        check("idle_ready_after_reset", 64'(req_ready), 64'd0);

        //            v        we       a0      a1      a2      a3      d0        d1        d2         d3          rdy      rsp
        tbl[0]  = mk(4'b0100, 4'b0100, 11'h000, 11'h000, 11'h005, 11'h000, 60'h0,    60'h0,    60'h0ABC,  60'h0,     4'b0100, 4'b0000);
        tbl[1]  = mk(4'b1000, 4'b1000, 11'h000, 11'h000, 11'h000, 11'h020, 60'h0,    60'h0,    60'h0,     60'h2020,  4'b1000, 4'b0000);
        tbl[2]  = mk(4'b0011, 4'b0001, 11'h010, 11'h020, 11'h000, 11'h000, 60'h1,    60'h0,    60'h0,     60'h0,     4'b0011, 4'b0000);
        tbl[3]  = mk(4'b0000, 4'b0000, 11'h000, 11'h000, 11'h000, 11'h000, 60'h0,    60'h0,    60'h0,     60'h0,     4'b0000, 4'b0000);
        tbl[4]  = mk(4'b0000, 4'b0000, 11'h000, 11'h000, 11'h000, 11'h000, 60'h0,    60'h0,    60'h0,     60'h0,     4'b0000, 4'b0010);
        tbl[5]  = mk(4'b1000, 4'b1000, 11'h000, 11'h000, 11'h000, 11'h030, 60'h0,    60'h0,    60'h0,     60'h3,     4'b1000, 4'b0000);
        tbl[6]  = mk(4'b0011, 4'b0011, 11'h7FF, 11'h7FF, 11'h000, 11'h000, 60'hAAA,  60'hBBB,  60'h0,     60'h0,     4'b0001, 4'b0000);
        tbl[7]  = mk(4'b0010, 4'b0010, 11'h000, 11'h7FF, 11'h000, 11'h000, 60'h0,    60'hBBB,  60'h0,     60'h0,     4'b0010, 4'b0000);
        tbl[8]  = mk(4'b0001, 4'b0000, 11'h7FF, 11'h000, 11'h000, 11'h000, 60'h0,    60'h0,    60'h0,     60'h0,     4'b0001, 4'b0000);
        tbl[9]  = mk(4'b0000, 4'b0000, 11'h000, 11'h000, 11'h000, 11'h000, 60'h0,    60'h0,    60'h0,     60'h0,     4'b0000, 4'b0000);
        tbl[10] = mk(4'b0000, 4'b0000, 11'h000, 11'h000, 11'h000, 11'h000, 60'h0,    60'h0,    60'h0,     60'h0,     4'b0000, 4'b0001);
        tbl[11] = mk(4'b0100, 4'b0100, 11'h000, 11'h000, 11'h040, 11'h000, 60'h0,    60'h0,    60'h4,     60'h0,     4'b0100, 4'b0000);
        tbl[12] = mk(4'b1001, 4'b0000, 11'h020, 11'h000, 11'h000, 11'h005, 60'h0,    60'h0,    60'h0,     60'h0,     4'b1001, 4'b0000);
        tbl[13] = mk(4'b1111, 4'b0000, 11'h005, 11'h010, 11'h020, 11'h030, 60'h0,    60'h0,    60'h0,     60'h0,     4'b0110, 4'b0000);
        tbl[14] = mk(4'b0000, 4'b0000, 11'h000, 11'h000, 11'h000, 11'h000, 60'h0,    60'h0,    60'h0,     60'h0,     4'b0000, 4'b1001);
        tbl[15] = mk(4'b0000, 4'b0000, 11'h000, 11'h000, 11'h000, 11'h000, 60'h0,    60'h0,    60'h0,     60'h0,     4'b0000, 4'b0110);
        tbl[16] = mk(4'b0011, 4'b0000, 11'h005, 11'h005, 11'h000, 11'h000, 60'h0,    60'h0,    60'h0,     60'h0,     4'b0011, 4'b0000);
        tbl[17] = mk(4'b0000, 4'b0000, 11'h000, 11'h000, 11'h000, 11'h000, 60'h0,    60'h0,    60'h0,     60'h0,     4'b0000, 4'b0000);
        tbl[18] = mk(4'b0000, 4'b0000, 11'h000, 11'h000, 11'h000, 11'h000, 60'h0,    60'h0,    60'h0,     60'h0,     4'b0000, 4'b0011);
        tbl[19] = mk(4'b0111, 4'b0101, 11'h050, 11'h060, 11'h050, 11'h000, 60'h5,    60'h0,    60'h6,     60'h0,     4'b0100, 4'b0000);
        tbl[20] = mk(4'b0000, 4'b0000, 11'h000, 11'h000, 11'h000, 11'h000, 60'h0,    60'h0,    60'h0,     60'h0,     4'b0000, 4'b0000);
        tbl[21] = mk(4'b1111, 4'b0000, 11'h005, 11'h010, 11'h020, 11'h030, 60'h0,    60'h0,    60'h0,     60'h0,     4'b1001, 4'b0000);
        tbl[22] = mk(4'b0000, 4'b0000, 11'h000, 11'h000, 11'h000, 11'h000, 60'h0,    60'h0,    60'h0,     60'h0,     4'b0000, 4'b0000);
        tbl[23] = mk(4'b0000, 4'b0000, 11'h000, 11'h000, 11'h000, 11'h000, 60'h0,    60'h0,    60'h0,     60'h0,     4'b0000, 4'b1001);

        for (int r = 0; r < 24; r++) begin
            run_cycle(tbl[r].v, tbl[r].we, tbl[r].a, tbl[r].d, 1'b1, tbl[r].exp_rdy, 1'b1, tbl[r].exp_rsp);
        end

        // Single read by requester 2 of the preloaded word.
        fa = '0;
        fa[2*AW +: AW] = 11'h005;
        run_cycle(4'b0100, 4'b0000, fa, '0, 1'b1, 4'b0100, 1'b1, 4'b0000);
        idle(1'b1, 4'b0000);
        idle(1'b1, 4'b0100);
        check("single_read_data", 64'(rsp_data[2*DW +: DW]), 64'h0ABC);
        idle(1'b1, 4'b0000);

        // Two reads accepted, reset lands before their responses.
        fa = {11'h030, 11'h020, 11'h010, 11'h005};
        run_cycle(4'b0011, 4'b0000, fa, '0, 1'b1, 4'b0011, 1'b1, 4'b0000);
        idle(1'b1, 4'b0000);
        do_reset();
        idle(1'b1, 4'b0000);
        idle(1'b1, 4'b0000);

        // All four reading continuously: pairs alternate, one response per requester every 2 cycles.
        for (int k = 0; k < 8; k++) begin
            run_cycle(4'b1111, 4'b0000, fa, '0, 1'b1, (k % 2 == 0) ? 4'b0011 : 4'b1100,
                      (k >= 2), (k % 2 == 0) ? 4'b0011 : 4'b1100);
        end
        idle(1'b1, 4'b0011);
        idle(1'b1, 4'b1100);
        idle(1'b1, 4'b0000);
        check("fairness_data_req3", 64'(rsp_data[3*DW +: DW]), 64'h3);

        // Random traffic over a small address window to provoke conflicts.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                ra[i*AW +: AW] = 11'h100 + 11'($urandom_range(0, 7));
                rnd = {$urandom, $urandom};
                rd[i*DW +: DW] = rnd[DW-1:0];
            end
            run_cycle(4'($urandom_range(0, 15)), 4'($urandom & $urandom), ra, rd, 1'b0, '0, 1'b0, '0);
        end
        idle(1'b0, '0);
        idle(1'b0, '0);
        idle(1'b1, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
